// File: rtl/cart_pkg.sv
// Shared constants for cartridge download buffering: header byte addresses
// and the flag values that identify CGB/SGB-aware images.
package cart_pkg;

  localparam logic [15:0] HDR_CGB_ADDR  = 16'h0142;
  localparam logic [15:0] HDR_SGB_ADDR  = 16'h0146;
  localparam logic [15:0] HDR_SIZE_ADDR = 16'h0148;
  localparam logic [15:0] HDR_LIC_ADDR  = 16'h014A;

  localparam logic [7:0] CGB_COMPAT  = 8'h80;
  localparam logic [7:0] CGB_ONLY    = 8'hC0;
  localparam logic [7:0] SGB_SUPPORT = 8'h03;
  localparam logic [7:0] OLD_LIC_NEW = 8'h33;

  function automatic logic is_cgb(input logic [7:0] flag);
    return (flag == CGB_COMPAT) || (flag == CGB_ONLY);
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Small power-of-two FIFO with a fill count; read data is the current head
// entry, so a pop consumes what rdata shows in the same cycle.
module dl_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cart_dl_buffer.sv
// Decouples loader writes from CPU-paced memory writes, snooping cartridge
// header bytes as words arrive and flagging when the image is fully written.
module cart_dl_buffer
  import cart_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 25,
  parameter int DEPTH  = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_cpu,
  input  logic              ce_cpu2x,
  input  logic              speed,
  input  logic              cart_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  output logic              dn_write,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_data,
  output logic              cart_ready,
  output logic              overflow_err,
  output logic [7:0]        cart_mbc_type,
  output logic [7:0]        cart_rom_size,
  output logic [7:0]        cart_ram_size,
  output logic [7:0]        cart_cgb_flag,
  output logic [7:0]        cart_sgb_flag,
  output logic [7:0]        cart_old_licensee,
  output logic              isGBC_game,
  output logic              isSGB_game
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = ADDR_W + DATA_W;

  logic          tick;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [FW-1:0] rdata;
  logic          dl_q;
  logic          dl_rise;
  logic          drained;

  assign tick    = speed ? ce_cpu2x : ce_cpu;
  assign dl_rise = cart_download & ~dl_q;
  assign push    = ioctl_wr & cart_download & ~full;
  assign pop     = tick & ~empty;

  dl_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wdata   ({ioctl_addr, ioctl_dout}),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_wait <= 1'b0;
      dn_write   <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dl_q       <= 1'b0;
    end else begin
      ioctl_wait <= (count >= CW'(DEPTH - 1));
      dn_write   <= pop;
      dl_q       <= cart_download;
      if (pop) begin
        dn_addr <= rdata[DATA_W +: ADDR_W];
        dn_data <= rdata[DATA_W-1:0];
      end
    end
  end

  // A new download wipes status; pushes/overflows in that same cycle still land.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cart_ready        <= 1'b0;
      overflow_err      <= 1'b0;
      drained           <= 1'b0;
      cart_mbc_type     <= '0;
      cart_rom_size     <= '0;
      cart_ram_size     <= '0;
      cart_cgb_flag     <= '0;
      cart_sgb_flag     <= '0;
      cart_old_licensee <= '0;
    end else begin
      if (dl_rise) begin
        cart_ready        <= 1'b0;
        overflow_err      <= 1'b0;
        drained           <= 1'b0;
        cart_mbc_type     <= '0;
        cart_rom_size     <= '0;
        cart_ram_size     <= '0;
        cart_cgb_flag     <= '0;
        cart_sgb_flag     <= '0;
        cart_old_licensee <= '0;
      end else begin
        if (pop) drained <= 1'b1;
        if (!cart_download && empty && !dn_write && drained) cart_ready <= 1'b1;
      end
      if (ioctl_wr && cart_download && full) overflow_err <= 1'b1;
      if (push) begin
        case (ioctl_addr)
          ADDR_W'(HDR_CGB_ADDR):  cart_cgb_flag <= ioctl_dout[15:8];
          ADDR_W'(HDR_SGB_ADDR):  {cart_mbc_type, cart_sgb_flag} <= ioctl_dout[15:0];
          ADDR_W'(HDR_SIZE_ADDR): {cart_ram_size, cart_rom_size} <= ioctl_dout[15:0];
          ADDR_W'(HDR_LIC_ADDR):  cart_old_licensee <= ioctl_dout[15:8];
          default: ;
        endcase
      end
    end
  end

  assign isGBC_game = is_cgb(cart_cgb_flag);
  assign isSGB_game = (cart_sgb_flag == SGB_SUPPORT) && (cart_old_licensee == OLD_LIC_NEW);

endmodule

// File: tb/tb_cart_dl_buffer.sv
// Directed bench for cart_dl_buffer: inputs change and outputs are sampled
// on the falling edge of clk_sys.
module tb_cart_dl_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 25;
  localparam int DEPTH  = 4;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ce_cpu;
  logic              ce_cpu2x;
  logic              speed;
  logic              cart_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [DATA_W-1:0] ioctl_dout;
  logic              ioctl_wait;
  logic              dn_write;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;
  logic              cart_ready;
  logic              overflow_err;
  logic [7:0]        cart_mbc_type;
  logic [7:0]        cart_rom_size;
  logic [7:0]        cart_ram_size;
  logic [7:0]        cart_cgb_flag;
  logic [7:0]        cart_sgb_flag;
  logic [7:0]        cart_old_licensee;
  logic              isGBC_game;
  logic              isSGB_game;

  int n_chk  = 0;
  int n_pass = 0;

  cart_dl_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_sys           (clk_sys),
    .reset             (reset),
    .ce_cpu            (ce_cpu),
    .ce_cpu2x          (ce_cpu2x),
    .speed             (speed),
    .cart_download     (cart_download),
    .ioctl_wr          (ioctl_wr),
    .ioctl_addr        (ioctl_addr),
    .ioctl_dout        (ioctl_dout),
    .ioctl_wait        (ioctl_wait),
    .dn_write          (dn_write),
    .dn_addr           (dn_addr),
    .dn_data           (dn_data),
    .cart_ready        (cart_ready),
    .overflow_err      (overflow_err),
    .cart_mbc_type     (cart_mbc_type),
    .cart_rom_size     (cart_rom_size),
    .cart_ram_size     (cart_ram_size),
    .cart_cgb_flag     (cart_cgb_flag),
    .cart_sgb_flag     (cart_sgb_flag),
    .cart_old_licensee (cart_old_licensee),
    .isGBC_game        (isGBC_game),
    .isSGB_game        (isSGB_game)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic set_tick(input logic tk);
    if (speed) ce_cpu2x = tk;
    else       ce_cpu   = tk;
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic tk);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    set_tick(tk);
    step();
    ioctl_wr = 1'b0;
    ce_cpu   = 1'b0;
    ce_cpu2x = 1'b0;
  endtask

  task automatic tick_once();
    set_tick(1'b1);
    step();
    ce_cpu   = 1'b0;
    ce_cpu2x = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] exp_a [2];
    logic [DATA_W-1:0] exp_d [2];
    int dw_cnt;
    int waited;

    reset = 1'b1; ce_cpu = 1'b0; ce_cpu2x = 1'b0; speed = 1'b0;
    cart_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) step();
    check("rst_wait",     ioctl_wait, 0);
    check("rst_dn_write", dn_write, 0);
    check("rst_ready",    cart_ready, 0);
    check("rst_ovf",      overflow_err, 0);
    check("rst_count",    dut.u_fifo.count, 0);
    reset = 1'b0;
    step();

    // Fill to full without drain ticks.
    cart_download = 1'b1;
    step();
    push_word(25'h142, 16'h8000, 1'b0);
    push_word(25'h146, 16'h1303, 1'b0);
    push_word(25'h148, 16'h0502, 1'b0);
    check("wait_lag",   ioctl_wait, 0);
    check("count_3",    dut.u_fifo.count, 3);
    step();
    check("wait_at_3",  ioctl_wait, 1);
    push_word(25'h14A, 16'h3300, 1'b0);
    check("count_4",    dut.u_fifo.count, 4);
    check("ovf_not_yet", overflow_err, 0);
    push_word(25'h142, 16'hC000, 1'b0);
    check("ovf_set",    overflow_err, 1);
    check("count_full", dut.u_fifo.count, 4);
    check("no_tick_dw", dn_write, 0);
    check("cgb_flag",   cart_cgb_flag, 8'h80);
    check("is_gbc",     isGBC_game, 1);
    check("mbc_type",   cart_mbc_type, 8'h13);
    check("sgb_flag",   cart_sgb_flag, 8'h03);
    check("rom_size",   cart_rom_size, 8'h02);
    check("ram_size",   cart_ram_size, 8'h05);
    check("old_lic",    cart_old_licensee, 8'h33);
    check("is_sgb",     isSGB_game, 1);

    // Drain at normal speed, then verify speed selects the other enable.
    tick_once();
    check("dw1",        dn_write, 1);
    check("dw1_addr",   dn_addr, 25'h142);
    check("dw1_data",   dn_data, 16'h8000);
    check("count_pop",  dut.u_fifo.count, 3);
    step();
    check("dw1_pulse",  dn_write, 0);
    speed = 1'b1;
    ce_cpu = 1'b1;
    step();
    ce_cpu = 1'b0;
    check("speed_sel",  dut.u_fifo.count, 3);
    step();
    check("speed_nodw", dn_write, 0);
    tick_once();
    check("dw2",        dn_write, 1);
    check("dw2_addr",   dn_addr, 25'h146);
    check("dw2_data",   dn_data, 16'h1303);
    step();
    check("wait_fall",  ioctl_wait, 0);

    // Push and pop together at count 2.
    push_word(25'h0, 16'h1111, 1'b1);
    check("pp_count",   dut.u_fifo.count, 2);
    check("pp_dw",      dn_write, 1);
    check("pp_addr",    dn_addr, 25'h148);
    check("pp_data",    dn_data, 16'h0502);
    check("pp_wait",    ioctl_wait, 0);
    step();
    check("pp_wait2",   ioctl_wait, 0);

    cart_download = 1'b0;
    push_word(25'h2, 16'h2222, 1'b0);
    check("idle_wr",    dut.u_fifo.count, 2);
    check("idle_ready", cart_ready, 0);

    exp_a[0] = 25'h14A; exp_d[0] = 16'h3300;
    exp_a[1] = 25'h0;   exp_d[1] = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      tick_once();
      check($sformatf("drain%0d_dw", i),   dn_write, 1);
      check($sformatf("drain%0d_addr", i), dn_addr, exp_a[i]);
      check($sformatf("drain%0d_data", i), dn_data, exp_d[i]);
      if (i == 0) check("ready_early", cart_ready, 0);
      for (int j = 0; j < 3; j++) begin
        step();
        check($sformatf("drain%0d_gap%0d", i, j), dn_write, 0);
      end
    end
    check("ready_set",  cart_ready, 1);
    repeat (5) step();
    check("ready_hold", cart_ready, 1);

    cart_download = 1'b1;
    step();
    check("rise_ready", cart_ready, 0);
    check("rise_ovf",   overflow_err, 0);
    check("rise_mbc",   cart_mbc_type, 0);
    check("rise_cgb",   cart_cgb_flag, 0);
    check("rise_rom",   cart_rom_size, 0);
    check("rise_lic",   cart_old_licensee, 0);
    check("rise_gbc",   isGBC_game, 0);
    check("rise_sgb",   isSGB_game, 0);

    // Reset with three entries queued and ticks running.
    push_word(25'h10, 16'hAAAA, 1'b0);
    push_word(25'h20, 16'hBBBB, 1'b0);
    push_word(25'h30, 16'hCCCC, 1'b0);
    check("pre_rst_cnt", dut.u_fifo.count, 3);
    reset = 1'b1;
    ce_cpu2x = 1'b1;
    step();
    check("mrst_dw",    dn_write, 0);
    check("mrst_wait",  ioctl_wait, 0);
    check("mrst_count", dut.u_fifo.count, 0);
    check("mrst_addr",  dn_addr, 0);
    check("mrst_data",  dn_data, 0);
    reset = 1'b0;
    dw_cnt = 0;
    repeat (6) begin
      step();
      if (dn_write) dw_cnt++;
    end
    ce_cpu2x = 1'b0;
    check("mrst_no_dw", dw_cnt, 0);

    cart_download = 1'b0;
    repeat (4) step();
    check("post_rst_ready", cart_ready, 0);
    cart_download = 1'b1;
    step();
    push_word(25'h40, 16'hABCD, 1'b0);
    cart_download = 1'b0;
    tick_once();
    check("resume_dw",   dn_write, 1);
    check("resume_addr", dn_addr, 25'h40);
    check("resume_data", dn_data, 16'hABCD);
    waited = 0;
    while (!cart_ready && waited < 8) begin
      step();
      waited++;
    end
    check("resume_ready", cart_ready, 1);
    check("resume_ovf",   overflow_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cart_dl_buffer.md
CART_DL_BUFFER -- requirements
Module: cart_dl_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: download word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 25: download byte-address width.
REQ-003 SHALL have parameter DEPTH, default 4: FIFO entries, a power of two and at least 2.
REQ-004 SHALL have port clk_sys, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port ce_cpu, input, 1: normal-speed CPU clock enable.
REQ-007 SHALL have port ce_cpu2x, input, 1: double-speed CPU clock enable.
REQ-008 SHALL have port speed, input, 1: selects ce_cpu2x when 1 and ce_cpu when 0 as drain tick.
REQ-009 SHALL have port cart_download, input, 1: cartridge download in progress.
REQ-010 SHALL have port ioctl_wr, input, 1: one-cycle write strobe from loader.
REQ-011 SHALL have port ioctl_addr, input, ADDR_W: byte address of ioctl_dout.
REQ-012 SHALL have port ioctl_dout, input, DATA_W: download word.
REQ-013 SHALL have port ioctl_wait, output, 1: loader back-pressure.
REQ-014 SHALL have port dn_write, output, 1: one-cycle memory write strobe.
REQ-015 SHALL have ports dn_addr, output, ADDR_W, and dn_data, output, DATA_W: write address and data, valid while dn_write=1.
REQ-016 SHALL have port cart_ready, output, 1: image fully written.
REQ-017 SHALL have port overflow_err, output, 1: sticky flag, ioctl_wr dropped because FIFO full.
REQ-018 SHALL have ports cart_mbc_type, cart_rom_size, cart_ram_size, cart_cgb_flag, cart_sgb_flag and cart_old_licensee, outputs, 8 each: captured header bytes.
REQ-019 SHALL have ports isGBC_game and isSGB_game, outputs, 1 each: header-derived flags.

Function
REQ-020 Push SHALL occur when ioctl_wr=1, cart_download=1 and FIFO not full, storing {ioctl_addr, ioctl_dout}.
REQ-021 When ioctl_wr=1 and the FIFO is full, the word SHALL be dropped and overflow_err set.
REQ-022 ioctl_wait SHALL be registered and equal 1 from the cycle after fill count reaches DEPTH-1 until count falls below DEPTH-1.
REQ-023 On a drain tick with FIFO non-empty, the head entry SHALL pop, and dn_write, dn_addr and dn_data SHALL be presented the next cycle for exactly one cycle.
REQ-024 Drain rate SHALL be at most one entry per drain tick; with no tick, dn_write SHALL stay 0.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged and preserve order; FIFO SHALL be first-in first-out.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-027 Header capture SHALL occur on push, not drain, on the low byte address of each word:
- 'h142: cart_cgb_flag=dout[15:8]
- 'h146: {cart_mbc_type, cart_sgb_flag}=dout
- 'h148: {cart_ram_size, cart_rom_size}=dout
- 'h14A: cart_old_licensee=dout[15:8]
REQ-028 isGBC_game SHALL be 1 when cart_cgb_flag is 8'h80 or 8'hC0.
REQ-029 isSGB_game SHALL be 1 when cart_sgb_flag=8'h03 and cart_old_licensee=8'h33.
REQ-030 A rising edge of cart_download SHALL clear all header registers, cart_ready and overflow_err and the internal drained flag, and SHALL NOT flush the FIFO.
REQ-031 cart_ready SHALL set when cart_download=0, FIFO empty, no dn_write pending and at least one entry drained since the last rising edge; it SHALL then hold until the next rising edge of cart_download.
REQ-032 ioctl_wr while cart_download=0 SHALL be ignored, with no push and no overflow_err.

Reset
REQ-033 Reset SHALL empty the FIFO and clear pointers, count, ioctl_wait, dn_write, dn_addr, dn_data, cart_ready, overflow_err, all header registers and the edge-detect register, all to 0.
REQ-034 Reset asserted mid-download SHALL discard pending entries; after release, operation SHALL resume normally and cart_ready SHALL require a new drained entry.

Structure
REQ-035 Header byte addresses ('h142, 'h146, 'h148, 'h14A) and flag constants (8'h80, 8'hC0, 8'h03, 8'h33) SHALL live in a shared package, cart_pkg.
REQ-036 The FIFO SHALL be a sub-module, dl_fifo, parametrised by width and DEPTH, with push/pop/full/empty/count ports.

Verification
REQ-037 With DEPTH=4, 3 pushes and no ticks, ioctl_wait SHALL go to 1; a 5th push SHALL be dropped and overflow_err=1.
REQ-038 Push addr 'h146, data 16'h1303; then cart_mbc_type=8'h13 and cart_sgb_flag=8'h03; with 'h14A data 16'h3300, isSGB_game=1.
REQ-039 Push 'h0, 'h2, 'h4 with a tick every 4 cycles: dn_write pulses 3 times, in order, each one cycle after a tick.
REQ-040 Simultaneous push and tick at count 2: count stays 2, and ioctl_wait is unchanged.
REQ-041 After download falls and the last entry drains, cart_ready=1; a new cart_download rise clears cart_ready and the header registers.
REQ-042 Reset asserted with 3 entries queued: no dn_write follows, and all outputs are 0 on the cycle after assertion.
